// File: rtl/car_gfx_pkg.sv
// Shared graphics constants for the car renderer: screen size, headings, colours and
// the blitter state encoding.
package car_gfx_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    // Headings, counter-clockwise from east.
    localparam logic [2:0] DIR_E  = 3'd0;
    localparam logic [2:0] DIR_NE = 3'd1;
    localparam logic [2:0] DIR_N  = 3'd2;
    localparam logic [2:0] DIR_NW = 3'd3;
    localparam logic [2:0] DIR_W  = 3'd4;
    localparam logic [2:0] DIR_SW = 3'd5;
    localparam logic [2:0] DIR_S  = 3'd6;
    localparam logic [2:0] DIR_SE = 3'd7;

    localparam logic [8:0] R = 9'h1C0;
    localparam logic [8:0] B = 9'h000;
    localparam logic [8:0] W = 9'h1FF;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} blit_state_e;

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major scan counter: column wraps at the scan width, then the row advances.
// Also tracks the linear index so no divide/modulo is needed for addressing.
module sprite_scan_counter #(
    parameter int unsigned CntW = 4,
    parameter int unsigned IdxW = 9
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            clear_i,
    input  logic            en_i,
    input  logic [CntW-1:0] width_i,
    input  logic [IdxW-1:0] n_i,
    output logic [CntW-1:0] r_o,
    output logic [CntW-1:0] c_o,
    output logic [IdxW-1:0] idx_o,
    output logic            last_o
);

    logic [CntW-1:0] r_q, c_q;
    logic [IdxW-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (!resetn || clear_i) begin
            r_q   <= '0;
            c_q   <= '0;
            idx_q <= '0;
        end else if (en_i) begin
            idx_q <= idx_q + IdxW'(1);
            if (c_q == width_i - CntW'(1)) begin
                c_q <= '0;
                r_q <= r_q + CntW'(1);
            end else begin
                c_q <= c_q + CntW'(1);
            end
        end
    end

    assign r_o    = r_q;
    assign c_o    = c_q;
    assign idx_o  = idx_q;
    assign last_o = (idx_q == n_i - IdxW'(1));

endmodule

// File: rtl/car_sprite_blitter.sv
// Rasterises a straight or diagonal car sprite from ROM into the VGA plot stream,
// with edge clipping, erase mode and a start/ready/done handshake.
module car_sprite_blitter
    import car_gfx_pkg::*;
#(
    parameter int unsigned X_SCREEN_PIXELS = SCREEN_W,
    parameter int unsigned Y_SCREEN_PIXELS = SCREEN_H,
    parameter int unsigned XW              = 8,
    parameter int unsigned YW              = 7,
    parameter int unsigned COLOUR_W        = 9,
    parameter int unsigned SW              = 8,
    parameter int unsigned SH              = 14,
    parameter int unsigned DS              = 15,
    parameter int unsigned BG_COLOUR       = 0,
    parameter int unsigned AW              = 9
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [XW-1:0]       iX,
    input  logic [YW-1:0]       iY,
    input  logic [2:0]          dir,
    input  logic                iErase,
    output logic [AW-1:0]       rom_addr,
    input  logic [COLOUR_W:0]   rom_data,
    output logic                oReady,
    output logic [XW-1:0]       oX,
    output logic [YW-1:0]       oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oPlot,
    output logic                oDone
);

    localparam int unsigned Dim1   = (SW > SH) ? SW : SH;
    localparam int unsigned MaxDim = (Dim1 > DS) ? Dim1 : DS;
    localparam int unsigned CntW   = $clog2(MaxDim + 1);
    localparam logic [AW-1:0] StraightN = AW'(SW * SH);
    localparam logic [AW-1:0] DiagN     = AW'(DS * DS);
    localparam logic [AW-1:0] DiagBase  = AW'(SW * SH);

    blit_state_e state_q, state_d;
    logic accept, cnt_clear, cnt_en, cnt_last;
    logic diag_in, transpose_in;

    logic [XW-1:0]       x0_q;
    logic [YW-1:0]       y0_q;
    logic                transpose_q, erase_q;
    logic [AW-1:0]       base_q, n_q, idx;
    logic [CntW-1:0]     width_q, r, c, x_off, y_off;
    logic [XW:0]         x_sum, s1_x_q;
    logic [YW:0]         y_sum, s1_y_q;
    logic                s1_valid_q;
    logic                plot_q, plot_d;
    logic [XW-1:0]       x_q;
    logic [YW-1:0]       y_q;
    logic [COLOUR_W-1:0] colour_q, colour_d;

    always_comb begin
        diag_in      = 1'b0;
        transpose_in = 1'b0;
        unique case (dir)
            DIR_E, DIR_W:   transpose_in = 1'b1;
            DIR_N, DIR_S:   transpose_in = 1'b0;
            DIR_NE, DIR_SW: diag_in = 1'b1;
            DIR_NW, DIR_SE: begin
                diag_in      = 1'b1;
                transpose_in = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept    = 1'b1;
                    cnt_clear = 1'b1;
                    state_d   = StRun;
                end
            end
            StRun: begin
                cnt_en = 1'b1;
                if (cnt_last) state_d = StDrain;
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
        endcase
    end

    sprite_scan_counter #(
        .CntW (CntW),
        .IdxW (AW)
    ) u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .width_i (width_q),
        .n_i     (n_q),
        .r_o     (r),
        .c_o     (c),
        .idx_o   (idx),
        .last_o  (cnt_last)
    );

    // Horizontal and down-right headings reuse the other image with rows/columns swapped.
    assign x_off = transpose_q ? r : c;
    assign y_off = transpose_q ? c : r;
    assign x_sum = {1'b0, x0_q} + (XW+1)'(x_off);
    assign y_sum = {1'b0, y0_q} + (YW+1)'(y_off);

    assign plot_d = s1_valid_q && rom_data[COLOUR_W] &&
                    (s1_x_q < (XW+1)'(X_SCREEN_PIXELS)) &&
                    (s1_y_q < (YW+1)'(Y_SCREEN_PIXELS));
    assign colour_d = erase_q ? COLOUR_W'(BG_COLOUR) : rom_data[COLOUR_W-1:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x0_q        <= '0;
            y0_q        <= '0;
            transpose_q <= 1'b0;
            erase_q     <= 1'b0;
            base_q      <= '0;
            n_q         <= '0;
            width_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            plot_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            colour_q    <= '0;
        end else begin
            if (accept) begin
                x0_q        <= iX;
                y0_q        <= iY;
                transpose_q <= transpose_in;
                erase_q     <= iErase;
                base_q      <= diag_in ? DiagBase : '0;
                n_q         <= diag_in ? DiagN : StraightN;
                width_q     <= diag_in ? CntW'(DS) : CntW'(SW);
            end
            // Stage 1 holds the coordinate of the pixel whose ROM word arrives now.
            s1_valid_q <= (state_q == StRun);
            s1_x_q     <= x_sum;
            s1_y_q     <= y_sum;
            plot_q     <= plot_d;
            x_q        <= s1_x_q[XW-1:0];
            y_q        <= s1_y_q[YW-1:0];
            colour_q   <= colour_d;
        end
    end

    assign rom_addr = base_q + idx;
    assign oReady   = (state_q == StIdle);
    assign oDone    = (state_q == StDone);
    assign oPlot    = plot_q;
    assign oX       = x_q;
    assign oY       = y_q;
    assign oColour  = colour_q;

endmodule

// File: tb/tb_car_sprite_blitter.sv
// Directed bench for car_sprite_blitter: vector table of draws plus reset corner cases.
module tb_car_sprite_blitter;
    import car_gfx_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] iX = '0;
    logic [6:0] iY = '0;
    logic [2:0] dir = '0;
    logic       iErase = 1'b0;
    logic [8:0] rom_addr;
    logic [9:0] rom_data;
    logic       oReady;
    logic [7:0] oX;
    logic [6:0] oY;
    logic [8:0] oColour;
    logic       oPlot;
    logic       oDone;

    logic [9:0] mem [512];

    int tests = 0;
    int fails = 0;

    car_sprite_blitter dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .iX       (iX),
        .iY       (iY),
        .dir      (dir),
        .iErase   (iErase),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .oReady   (oReady),
        .oX       (oX),
        .oY       (oY),
        .oColour  (oColour),
        .oPlot    (oPlot),
        .oDone    (oDone)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one cycle of read latency.
    always_ff @(posedge clk) rom_data <= mem[rom_addr];

    typedef struct {
        logic [2:0] dir;
        int x, y;
        bit erase;
        int mode;
        int paddr;
        int pcyc;
        bit pplot;
        int px, py, pcol;
        int plots;
        int done_cyc;
        int glitch;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // mode 0: only paddr opaque (R); 1: all opaque (W); 2: odd addresses opaque (W).
    task automatic fill(input int mode, input int paddr);
        for (int a = 0; a < 512; a++) begin
            case (mode)
                0:       mem[a] = (a == paddr) ? {1'b1, R} : 10'h000;
                1:       mem[a] = {1'b1, W};
                default: mem[a] = a[0] ? {1'b1, W} : 10'h0FF;
            endcase
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int plots = 0;
        int done_at = -1;
        int dones = 0;
        int oob = 0;
        int badcol = 0;
        int expcol;
        expcol = v.erase ? 0 : ((v.mode == 0) ? int'(R) : int'(W));
        fill(v.mode, v.paddr);
        @(negedge clk);
        start  = 1'b1;
        iX     = 8'(v.x);
        iY     = 7'(v.y);
        dir    = v.dir;
        iErase = v.erase;
        @(negedge clk);
        // Scramble inputs after acceptance; the draw must not see this.
        start  = 1'b0;
        iX     = ~iX;
        iY     = 7'h55;
        dir    = dir + 3'd1;
        iErase = ~iErase;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (cyc == v.glitch) begin
                chk({tag, " ready_in_run"}, int'(oReady), 0);
                start = 1'b1;
                iX    = 8'd100;
            end else begin
                start = 1'b0;
            end
            if (oPlot) begin
                plots++;
                if (oX >= 8'd160 || oY >= 7'd120) oob++;
                if (int'(oColour) != expcol) badcol++;
            end
            if (cyc == v.pcyc) begin
                chk({tag, " probe_plot"}, int'(oPlot), int'(v.pplot));
                if (v.pplot) begin
                    chk({tag, " probe_x"}, int'(oX), v.px);
                    chk({tag, " probe_y"}, int'(oY), v.py);
                    chk({tag, " probe_colour"}, int'(oColour), v.pcol);
                end
            end
            if (oDone) begin
                dones++;
                if (done_at < 0) done_at = cyc;
            end
            if (done_at > 0 && cyc == done_at + 1) chk({tag, " ready_after"}, int'(oReady), 1);
            if (done_at > 0 && cyc >= done_at + 6) break;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, " done_cycle"}, done_at, v.done_cyc);
        chk({tag, " done_pulses"}, dones, 1);
        chk({tag, " plot_count"}, plots, v.plots);
        chk({tag, " out_of_bounds"}, oob, 0);
        chk({tag, " colour"}, badcol, 0);
    endtask

    initial begin
        int dones;
        //           dir   x    y   er mode paddr pcyc pp  px   py   pcol plots done glitch
        vecs[0] = '{3'd2, 10,  20,  0, 0,   0,    3,   1, 10,  20,  448, 1,   114, 0};
        vecs[1] = '{3'd0, 10,  20,  0, 0,   8,    11,  1, 11,  20,  448, 1,   114, 0};
        vecs[2] = '{3'd3, 150, 110, 0, 1,   112,  3,   1, 150, 110, 511, 100, 227, 0};
        vecs[3] = '{3'd6, 10,  20,  1, 2,   1,    4,   1, 11,  20,  0,   56,  114, 0};
        vecs[4] = '{3'd1, 0,   0,   0, 0,   128,  19,  1, 1,   1,   448, 1,   227, 0};
        vecs[5] = '{3'd2, 152, 106, 0, 1,   111,  114, 1, 159, 119, 511, 112, 114, 0};
        vecs[6] = '{3'd2, 153, 107, 0, 1,   111,  114, 0, 0,   0,   0,   91,  114, 0};
        vecs[7] = '{3'd4, 30,  40,  0, 0,   9,    12,  1, 31,  41,  448, 1,   114, 20};
        vecs[8] = '{3'd7, 20,  30,  0, 0,   129,  20,  1, 21,  32,  448, 1,   227, 0};

        fill(0, 0);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset oPlot", int'(oPlot), 0);
        chk("reset oDone", int'(oDone), 0);
        chk("reset oReady", int'(oReady), 1);
        chk("reset rom_addr", int'(rom_addr), 0);
        chk("reset oX", int'(oX), 0);
        chk("reset oColour", int'(oColour), 0);
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a straight draw.
        fill(1, 0);
        @(negedge clk);
        start = 1'b1;
        iX    = 8'd10;
        iY    = 7'd20;
        dir   = 3'd2;
        iErase = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 50; cyc++) @(negedge clk);
        chk("midrun plotting", int'(oPlot), 1);
        resetn = 1'b0;
        @(negedge clk);
        chk("midreset oPlot", int'(oPlot), 0);
        chk("midreset oX", int'(oX), 0);
        chk("midreset oY", int'(oY), 0);
        chk("midreset oColour", int'(oColour), 0);
        chk("midreset oDone", int'(oDone), 0);
        chk("midreset rom_addr", int'(rom_addr), 0);
        chk("midreset oReady", int'(oReady), 1);
        resetn = 1'b1;
        dones = 0;
        for (int cyc = 0; cyc < 130; cyc++) begin
            if (oDone || oPlot) dones++;
            @(negedge clk);
        end
        chk("midreset no_activity", dones, 0);
        run_vec(vecs[0], "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/car_sprite_blitter.md
# car_sprite_blitter

Parametrised sprite drawer that rasterises an 8-direction car sprite into the VGA pixel stream at a latched top-left coordinate. It is the next generation of the car draw engine, with these additions:
- sprite geometry, screen size and colour width are parameters;
- the ROM read is pipelined;
- a start/ready/done handshake;
- screen-edge clipping;
- an erase mode that repaints the footprint in background colour.

It sits between the game-logic FSM (which issues `start` per frame) and the VGA adapter's plot port.

## Interface
Parameters:
- `X_SCREEN_PIXELS`, 160: screen width.
- `Y_SCREEN_PIXELS`, 120: screen height.
- `XW`, 8: x coordinate width.
- `YW`, 7: y coordinate width.
- `COLOUR_W`, 9: colour width ({R,G,B}, 3 bits each).
- `SW`, 8: straight-sprite width (columns).
- `SH`, 14: straight-sprite height (rows).
- `DS`, 15: diagonal-sprite side.
- `BG_COLOUR`, 0: colour used in erase mode.
- `AW`, 9: ROM address width. Must satisfy 2^AW ≥ SW·SH + DS·DS.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: request to draw. Sampled only while `oReady` is 1.
- `iX` in XW: top-left x of the sprite.
- `iY` in YW: top-left y of the sprite.
- `dir` in 3: heading 0–7. Even values are straight, odd values are diagonal.
- `iErase` in 1: 1 = paint BG_COLOUR instead of sprite colour.
- `rom_addr` out AW: sprite ROM address.
- `rom_data` in COLOUR_W+1: ROM word. MSB = opaque flag, low bits = colour. Read latency is 1 cycle.
- `oReady` out 1: high only in IDLE.
- `oX` out XW: plot x.
- `oY` out YW: plot y.
- `oColour` out COLOUR_W: plot colour.
- `oPlot` out 1: write strobe to the VGA adapter.
- `oDone` out 1: 1-cycle pulse marking the end of the draw.

## Operation
ROM layout:
- Straight image: addresses 0..SW·SH−1, row-major, SW columns by SH rows (car pointing vertically).
- Diagonal image: base SW·SH, DS·DS entries, row-major, car pointing up-right.

Start:
- On `start` while in IDLE, the block latches iX, iY, dir and iErase.
- It selects the image base and the scan size:
  - straight: N = SW·SH, scan width SW;
  - diagonal: N = DS·DS, scan width DS.

Scan:
- Row counter r and column counter c run row-major. c wraps at the scan width and then r increments. No divide or modulo is used.
- `rom_addr` = base + linear index.

Coordinate mapping:
- dir 2/6 (vertical) and 1/5 (up-right): x = X + c, y = Y + r.
- dir 0/4 (horizontal) and 3/7 (down-right): transposed, x = X + r, y = Y + c.
- Sums are computed one bit wider than XW/YW.

Plot rule:
- `oPlot` = opaque AND x < X_SCREEN_PIXELS AND y < Y_SCREEN_PIXELS.
- `oColour` = BG_COLOUR if erase, else rom_data[COLOUR_W−1:0].
- Transparent or clipped pixels still consume their cycle. They drive `oPlot` = 0 and leave oX/oY/oColour at don't-care values.

FSM: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: `oReady` = 1. Go to RUN on `start`.
- RUN: one address per cycle for N cycles. Leave RUN on the last index.
- DRAIN: 1 cycle, waiting for the final ROM word.
- DONE: `oDone` = 1 for 1 cycle. Return to IDLE.

`start` outside IDLE is ignored; no queueing.

Changes to iX, iY, dir or iErase after acceptance have no effect on the draw in progress.

## Timing
- Cycle 0: `start` is sampled in IDLE.
- Cycles 1..N: RUN. The address for pixel k is driven in cycle k+1.
- rom_data for pixel k is valid in cycle k+2.
- oX, oY, oColour and oPlot are registered. Pixel k is visible in cycle k+3.
- Cycle N+1: DRAIN.
- Cycle N+2: DONE. The last pixel and `oDone` are visible together. `oReady` returns to 1 in cycle N+3.
- Throughput: one pixel per cycle. A new `start` is accepted in cycle N+3 at the earliest.
- Reset values: `oX`, `oY`, `oColour`, `oPlot`, `oDone` and `rom_addr` are all 0; state is IDLE; `oReady` = 1.
- Reset mid-operation: all outputs are 0 on the next cycle, no `oDone` is issued, and the pipeline contents are discarded.
- Clipping boundary: pixel at x = 159 is plotted; pixel at x = 160 is suppressed. The same rule applies to y at 119 and 120.

## Structure
- Shared package `car_gfx_pkg` holds:
  - the screen-size constants;
  - the dir encodings (DIR_E = 0 … DIR_SE = 7);
  - the colour constants R = 9'h1C0, B = 9'h000, W = 9'h1FF;
  - the FSM state enum.
- Sub-module `sprite_scan_counter`:
  - parameterised row/column counter;
  - inputs: clear, enable, scan width, N;
  - outputs: r, c, linear index, last flag.
- Sprite ROM contents live outside this block, in a separate initialised memory.

## Test plan
1. Reset check: hold resetn=0 for 2 cycles → oPlot=0, oDone=0, oReady=1, rom_addr=0.
2. Vertical draw: dir=2, (10,20); ROM word 0 = opaque 0x1C0 → cycle 3 shows oPlot=1, oX=10, oY=20, oColour=0x1C0; oDone in cycle 114.
3. Horizontal transpose: dir=0, (10,20); opaque at address 8 (r=1, c=0) → plot at x=11, y=20 in cycle 11.
4. Diagonal clipping: dir=3, (150,110); all-opaque ROM → no oPlot with x ≥ 160 or y ≥ 120; exactly 100 plots; oDone in cycle 227.
5. Erase: iErase=1, dir=6 → every oPlot carries oColour=BG_COLOUR; plot count equals the opaque count.
6. Reset at cycle 50 of a straight draw → outputs 0 next cycle, no oDone; the following start runs a full 114-cycle draw; start pulsed during RUN is ignored.
